// File: rtl/irq_encoder_8_to_3.sv
// Registered 8-to-3 priority encoder: captures request rising edges into a sticky
// pending register and presents one unmasked index at a time under a valid/ack handshake.
module irq_encoder_8_to_3 #(
  parameter bit LOW_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic [7:0] mask,
  input  logic       en,
  input  logic       ack,
  output logic [2:0] y,
  output logic       valid,
  output logic [7:0] pending
);

  typedef enum logic {
    S_IDLE    = 1'b0,
    S_PRESENT = 1'b1
  } state_t;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [7:0] r_req_q;
  logic [7:0] r_pending;
  logic [7:0] w_pending_nxt;
  logic [7:0] w_rise;
  logic [7:0] w_cand;
  logic [7:0] w_clr;
  logic [2:0] r_y;
  logic [2:0] w_y_nxt;
  logic [2:0] w_sel;
  logic       r_valid;
  logic       w_valid_nxt;

  // Later loop assignments win, so the scan direction sets the priority.
  function automatic logic [2:0] f_select(input logic [7:0] c);
    logic [2:0] idx;
    idx = 3'd0;
    if (LOW_FIRST) begin
      for (int i = 7; i >= 0; i--) begin
        if (c[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 0; i < 8; i++) begin
        if (c[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  // Next-state, presentation and retire decode.
  always_comb begin
    w_rise      = req & ~r_req_q;
    w_cand      = r_pending & ~mask;
    w_sel       = f_select(w_cand);
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_valid_nxt = r_valid;
    w_clr       = 8'h00;
    case (r_state)
      S_IDLE: begin
        if (en && (w_cand != 8'h00)) begin
          w_state_nxt = S_PRESENT;
          w_y_nxt     = w_sel;
          w_valid_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      S_PRESENT: begin
        if (ack) begin
          w_state_nxt = S_IDLE;
          w_valid_nxt = 1'b0;
          w_clr       = 8'h01 << r_y;
        end else begin
          w_state_nxt = S_PRESENT;
          w_valid_nxt = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
    // A new rise on the retiring bit keeps it pending.
    w_pending_nxt = (r_pending & ~w_clr) | w_rise;
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Request history, pending set and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_req_q   <= 8'h00;
      r_pending <= 8'h00;
      r_y       <= 3'd0;
      r_valid   <= 1'b0;
    end else begin
      r_req_q   <= req;
      r_pending <= w_pending_nxt;
      r_y       <= w_y_nxt;
      r_valid   <= w_valid_nxt;
    end
  end

  assign y       = r_y;
  assign valid   = r_valid;
  assign pending = r_pending;

endmodule

// File: tb/tb_irq_encoder_8_to_3.sv
// Bench for irq_encoder_8_to_3: directed scenarios plus randomized traffic checked
// against a behavioural model, on a lowest-first and a highest-first instance.
module tb_irq_encoder_8_to_3;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic [7:0] mask;
  logic       en;
  logic       ack;
  logic [2:0] y_lo, y_hi;
  logic       valid_lo, valid_hi;
  logic [7:0] pend_lo, pend_hi;
  int         n_pass = 0;
  int         n_total = 0;

  irq_encoder_8_to_3 #(.LOW_FIRST(1'b1)) dut_lo (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .en(en), .ack(ack),
    .y(y_lo), .valid(valid_lo), .pending(pend_lo)
  );

  irq_encoder_8_to_3 #(.LOW_FIRST(1'b0)) dut_hi (
    .clk(clk), .rst(rst), .req(req), .mask(mask), .en(en), .ack(ack),
    .y(y_hi), .valid(valid_hi), .pending(pend_hi)
  );

  always #5 clk = ~clk;

  // Reference model: index 0 is lowest-first, index 1 is highest-first.
  logic [7:0] m_prev;
  logic [7:0] m_pend [2];
  logic [2:0] m_y [2];
  logic       m_valid [2];

  function automatic logic [2:0] m_pick(input logic [7:0] c, input bit low_first);
    int ci;
    ci = int'(c);
    if (low_first) return 3'($clog2(ci & -ci));
    else return 3'($clog2(ci + 1) - 1);
  endfunction

  function automatic logic [7:0] m_next_pend(input logic [7:0] p, input logic v,
                                             input logic [2:0] idx, input logic a,
                                             input logic [7:0] r, input logic [7:0] prev);
    logic [7:0] n;
    for (int b = 0; b < 8; b++) begin
      n[b] = (r[b] && !prev[b]) || (p[b] && !(v && a && (int'(idx) == b)));
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_prev <= 8'h00;
      for (int v = 0; v < 2; v++) begin
        m_pend[v]  <= 8'h00;
        m_y[v]     <= 3'd0;
        m_valid[v] <= 1'b0;
      end
    end else begin
      m_prev <= req;
      for (int v = 0; v < 2; v++) begin
        m_pend[v] <= m_next_pend(m_pend[v], m_valid[v], m_y[v], ack, req, m_prev);
        if (!m_valid[v]) begin
          if (en && ((m_pend[v] & ~mask) != 8'h00)) begin
            m_valid[v] <= 1'b1;
            m_y[v]     <= m_pick(m_pend[v] & ~mask, v == 0);
          end
        end else if (ack) begin
          m_valid[v] <= 1'b0;
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 8'h00; mask = 8'h00; en = 1'b1; ack = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_total++; if (valid_lo !== 1'b0) $display("FAIL reset_valid_lo: got %0b want 0", valid_lo); else n_pass++;
    n_total++; if (y_lo !== 3'd0) $display("FAIL reset_y_lo: got %0d want 0", y_lo); else n_pass++;
    n_total++; if (pend_lo !== 8'h00) $display("FAIL reset_pend_lo: got %h want 00", pend_lo); else n_pass++;
    n_total++; if (valid_hi !== 1'b0 || pend_hi !== 8'h00) $display("FAIL reset_hi: got v=%0b p=%h want v=0 p=00", valid_hi, pend_hi); else n_pass++;
  endtask

  task automatic test_basic();
    req = 8'h20;
    tick(); req = 8'h00;
    n_total++; if (pend_lo !== 8'h20) $display("FAIL basic_capture: got %h want 20", pend_lo); else n_pass++;
    n_total++; if (valid_lo !== 1'b0) $display("FAIL basic_not_yet_valid: got %0b want 0", valid_lo); else n_pass++;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_total++; if (valid_lo !== 1'b1 || y_lo !== 3'd5) $display("FAIL basic_present: got v=%0b y=%0d want v=1 y=5", valid_lo, y_lo); else n_pass++;
      if (i < 3) tick();
    end
    ack = 1'b1; tick(); ack = 1'b0;
    n_total++; if (valid_lo !== 1'b0 || pend_lo !== 8'h00) $display("FAIL basic_retire: got v=%0b p=%h want v=0 p=00", valid_lo, pend_lo); else n_pass++;
  endtask

  task automatic test_priority();
    logic [2:0] exp_lo [3];
    logic [2:0] exp_hi [3];
    exp_lo = '{3'd0, 3'd4, 3'd7};
    exp_hi = '{3'd7, 3'd4, 3'd0};
    req = 8'h91; tick(); req = 8'h00; tick();
    for (int k = 0; k < 3; k++) begin
      n_total++; if (valid_lo !== 1'b1 || y_lo !== exp_lo[k]) $display("FAIL prio_lo_%0d: got v=%0b y=%0d want v=1 y=%0d", k, valid_lo, y_lo, exp_lo[k]); else n_pass++;
      n_total++; if (valid_hi !== 1'b1 || y_hi !== exp_hi[k]) $display("FAIL prio_hi_%0d: got v=%0b y=%0d want v=1 y=%0d", k, valid_hi, y_hi, exp_hi[k]); else n_pass++;
      ack = 1'b1; tick(); ack = 1'b0;
      n_total++; if (valid_lo !== 1'b0 || valid_hi !== 1'b0) $display("FAIL prio_gap_%0d: got v_lo=%0b v_hi=%0b want 0 0", k, valid_lo, valid_hi); else n_pass++;
      tick();
    end
    n_total++; if (valid_lo !== 1'b0 || pend_lo !== 8'h00 || pend_hi !== 8'h00) $display("FAIL prio_drained: got v=%0b p_lo=%h p_hi=%h want 0 00 00", valid_lo, pend_lo, pend_hi); else n_pass++;
  endtask

  task automatic test_mask();
    mask = 8'h01; req = 8'h03; tick(); req = 8'h00; tick();
    n_total++; if (valid_lo !== 1'b1 || y_lo !== 3'd1) $display("FAIL mask_first: got v=%0b y=%0d want v=1 y=1", valid_lo, y_lo); else n_pass++;
    ack = 1'b1; tick(); ack = 1'b0; tick();
    n_total++; if (valid_lo !== 1'b0 || pend_lo !== 8'h01) $display("FAIL mask_held: got v=%0b p=%h want v=0 p=01", valid_lo, pend_lo); else n_pass++;
    mask = 8'h00; tick(); tick();
    n_total++; if (valid_lo !== 1'b1 || y_lo !== 3'd0) $display("FAIL mask_unmask: got v=%0b y=%0d want v=1 y=0", valid_lo, y_lo); else n_pass++;
    ack = 1'b1; tick(); ack = 1'b0; tick();
  endtask

  task automatic test_en();
    en = 1'b0; req = 8'h08; tick(); req = 8'h00;
    for (int i = 0; i < 10; i++) begin
      tick();
      n_total++; if (valid_lo !== 1'b0) $display("FAIL en_blocked_%0d: got %0b want 0", i, valid_lo); else n_pass++;
    end
    en = 1'b1; tick();
    n_total++; if (valid_lo !== 1'b1 || y_lo !== 3'd3) $display("FAIL en_present: got v=%0b y=%0d want v=1 y=3", valid_lo, y_lo); else n_pass++;
    req = 8'h02; en = 1'b0; tick(); req = 8'h00;
    n_total++; if (pend_lo !== 8'h0A) $display("FAIL en_capture: got %h want 0a", pend_lo); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      n_total++; if (valid_lo !== 1'b1 || y_lo !== 3'd3) $display("FAIL en_hold_%0d: got v=%0b y=%0d want v=1 y=3", i, valid_lo, y_lo); else n_pass++;
      tick();
    end
    ack = 1'b1; tick(); ack = 1'b0;
    n_total++; if (valid_lo !== 1'b0 || pend_lo !== 8'h02) $display("FAIL en_retire: got v=%0b p=%h want v=0 p=02", valid_lo, pend_lo); else n_pass++;
    en = 1'b1; tick();
    n_total++; if (valid_lo !== 1'b1 || y_lo !== 3'd1) $display("FAIL en_next: got v=%0b y=%0d want v=1 y=1", valid_lo, y_lo); else n_pass++;
    ack = 1'b1; tick(); ack = 1'b0; tick();
  endtask

  task automatic test_collision();
    req = 8'h04; tick(); req = 8'h00; tick();
    n_total++; if (valid_lo !== 1'b1 || y_lo !== 3'd2) $display("FAIL coll_present: got v=%0b y=%0d want v=1 y=2", valid_lo, y_lo); else n_pass++;
    ack = 1'b1; req = 8'h04; tick(); ack = 1'b0;
    n_total++; if (valid_lo !== 1'b0 || pend_lo !== 8'h04) $display("FAIL coll_keep: got v=%0b p=%h want v=0 p=04", valid_lo, pend_lo); else n_pass++;
    tick();
    n_total++; if (valid_lo !== 1'b1 || y_lo !== 3'd2) $display("FAIL coll_again: got v=%0b y=%0d want v=1 y=2", valid_lo, y_lo); else n_pass++;
    ack = 1'b1; tick(); ack = 1'b0; req = 8'h00;
    n_total++; if (valid_lo !== 1'b0 || pend_lo !== 8'h00) $display("FAIL coll_retire: got v=%0b p=%h want v=0 p=00", valid_lo, pend_lo); else n_pass++;
    ack = 1'b1; tick(); ack = 1'b0; tick();
    n_total++; if (valid_lo !== 1'b0 || pend_lo !== 8'h00 || y_lo !== 3'd2) $display("FAIL idle_ack: got v=%0b p=%h y=%0d want v=0 p=00 y=2", valid_lo, pend_lo, y_lo); else n_pass++;
  endtask

  task automatic test_async_reset();
    mask = 8'h00; en = 1'b1; req = 8'hFF; tick(); tick();
    n_total++; if (valid_lo !== 1'b1 || pend_lo !== 8'hFF) $display("FAIL areset_setup: got v=%0b p=%h want v=1 p=ff", valid_lo, pend_lo); else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++; if (valid_lo !== 1'b0 || y_lo !== 3'd0 || pend_lo !== 8'h00) $display("FAIL areset_lo: got v=%0b y=%0d p=%h want 0 0 00", valid_lo, y_lo, pend_lo); else n_pass++;
    n_total++; if (valid_hi !== 1'b0 || y_hi !== 3'd0 || pend_hi !== 8'h00) $display("FAIL areset_hi: got v=%0b y=%0d p=%h want 0 0 00", valid_hi, y_hi, pend_hi); else n_pass++;
    tick(); rst = 1'b0; tick();
    n_total++; if (pend_lo !== 8'hFF || valid_lo !== 1'b0) $display("FAIL areset_recapture: got p=%h v=%0b want p=ff v=0", pend_lo, valid_lo); else n_pass++;
  endtask

  task automatic test_random();
    rst = 1'b1; req = 8'h00; ack = 1'b0; tick(); rst = 1'b0;
    for (int i = 0; i < 400; i++) begin
      tick();
      n_total++; if (y_lo !== m_y[0] || valid_lo !== m_valid[0]) $display("FAIL rand_out_lo_%0d: got v=%0b y=%0d want v=%0b y=%0d", i, valid_lo, y_lo, m_valid[0], m_y[0]); else n_pass++;
      n_total++; if (pend_lo !== m_pend[0]) $display("FAIL rand_pend_lo_%0d: got %h want %h", i, pend_lo, m_pend[0]); else n_pass++;
      n_total++; if (y_hi !== m_y[1] || valid_hi !== m_valid[1]) $display("FAIL rand_out_hi_%0d: got v=%0b y=%0d want v=%0b y=%0d", i, valid_hi, y_hi, m_valid[1], m_y[1]); else n_pass++;
      n_total++; if (pend_hi !== m_pend[1]) $display("FAIL rand_pend_hi_%0d: got %h want %h", i, pend_hi, m_pend[1]); else n_pass++;
      req  = 8'($urandom);
      mask = 8'($urandom & $urandom);
      en   = ($urandom_range(0, 3) != 0);
      ack  = 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_priority();
    test_mask();
    test_en();
    test_collision();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
